// File: rtl/ofdm_symbol_sequencer_if.sv
// Sample-stream bundle around the OFDM symbol sequencer: the upstream
// plateau-detector stream (i_*) and the downstream FFT stream (o_*).
interface ofdm_symbol_sequencer_if #(
  parameter int WIDTH_SAMPLE = 16
);
  logic [2*WIDTH_SAMPLE-1:0] i_tdata;
  logic                      i_tlast;
  logic                      i_tvalid;
  logic                      i_tready;
  logic [2*WIDTH_SAMPLE-1:0] o_tdata;
  logic                      o_tlast;
  logic                      o_tuser;
  logic                      o_tvalid;
  logic                      o_tready;

  // Environment side: feeds samples in and consumes symbols out.
  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tuser, o_tvalid
  );

  // Sequencer side.
  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tuser, o_tvalid
  );
endinterface

// File: rtl/ofdm_symbol_sequencer.sv
// OFDM frame sequencer: on a detector trigger, drops the preamble, strips each
// cyclic prefix and releases FFT_SIZE-sample symbols with symbol framing.
module ofdm_symbol_sequencer #(
  parameter int WIDTH_SAMPLE        = 16,
  parameter int FFT_SIZE            = 64,
  parameter int CP_LEN              = 16,
  parameter int SKIP_LEN_DEFAULT    = 320,
  parameter int NUM_SYMBOLS_DEFAULT = 1,
  parameter int SR_NUM_SYMBOLS      = 7,
  parameter int SR_SKIP_LEN         = 8,
  parameter int SR_ABORT            = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        set_stb,
  input  logic [7:0]                  set_addr,
  input  logic [31:0]                 set_data,
  ofdm_symbol_sequencer_if.slave      s,
  output logic                        frame_active,
  output logic                        frame_done,
  output logic [15:0]                 retrigger_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CP, S_SYMBOL} state_t;

  // Wide enough for the full 10-bit skip range and for one symbol.
  localparam int CNT_W = ($clog2(FFT_SIZE) > 10) ? $clog2(FFT_SIZE) : 10;

  state_t                    state, state_d;
  logic [7:0]                num_symbols_reg, num_sym_q, sym_cnt, sym_cnt_d;
  logic [9:0]                skip_len_reg, skip_q;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic [2*WIDTH_SAMPLE-1:0] data_q;
  logic                      tlast_q, tuser_q, tvalid_q, final_q;
  logic                      accept, abort, load_out, latch_cfg, last_beat, final_beat;
  logic                      unused_set_data;

  assign abort           = set_stb && (set_addr == 8'(SR_ABORT));
  assign s.i_tready      = (state == S_SYMBOL) ? (~tvalid_q | s.o_tready) : 1'b1;
  assign accept          = s.i_tvalid & s.i_tready;
  assign unused_set_data = ^set_data[31:10];

  // Programmable registers; the frame works from copies taken at the trigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_symbols_reg <= 8'(NUM_SYMBOLS_DEFAULT);
      skip_len_reg    <= 10'(SKIP_LEN_DEFAULT);
    end else if (set_stb) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (set_addr == 8'(SR_NUM_SYMBOLS)) num_symbols_reg <= set_data[7:0];
      if (set_addr == 8'(SR_SKIP_LEN))    skip_len_reg    <= set_data[9:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sym_cnt   <= '0;
      num_sym_q <= '0;
      skip_q    <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      sym_cnt <= sym_cnt_d;
      if (latch_cfg) begin
        num_sym_q <= num_symbols_reg;
        skip_q    <= skip_len_reg;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state;
    cnt_d      = cnt;
    sym_cnt_d  = sym_cnt;
    latch_cfg  = 1'b0;
    load_out   = 1'b0;
    last_beat  = 1'b0;
    final_beat = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept && s.i_tlast && (num_symbols_reg != 8'd0)) begin
          latch_cfg = 1'b1;
          cnt_d     = '0;
          sym_cnt_d = '0;
          state_d   = (skip_len_reg == 10'd0) ? S_CP : S_SKIP;
        end
      end
      S_SKIP: begin
        if (accept) begin
          if (cnt == CNT_W'(skip_q - 10'd1)) begin
            cnt_d   = '0;
            state_d = S_CP;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      S_CP: begin
        if (accept) begin
          if (cnt == CNT_W'(CP_LEN - 1)) begin
            cnt_d   = '0;
            state_d = S_SYMBOL;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      S_SYMBOL: begin
        if (accept) begin
          load_out = 1'b1;
          if (cnt == CNT_W'(FFT_SIZE - 1)) begin
            last_beat = 1'b1;
            cnt_d     = '0;
            sym_cnt_d = sym_cnt + 8'd1;
            if (sym_cnt_d == num_sym_q) begin
              final_beat = 1'b1;
              state_d    = S_IDLE;
            end else begin
              state_d = S_CP;
            end
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort beats any trigger or load arriving in the same cycle.
    if (abort) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      latch_cfg = 1'b0;
      load_out  = 1'b0;
    end
  end

  // Single-stage output register; final_q tags the frame's closing beat so
  // frame_done can follow its handshake even after the FSM has gone idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the data register is reset too because o_tdata must read 0 out of reset.
      data_q   <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
      final_q  <= 1'b0;
    end else if (abort) begin
      tvalid_q <= 1'b0;
      final_q  <= 1'b0;
    end else if (load_out) begin
      data_q   <= s.i_tdata;
      tlast_q  <= last_beat;
      tuser_q  <= (cnt == '0) && (sym_cnt == 8'd0);
      tvalid_q <= 1'b1;
      final_q  <= final_beat;
    end else if (s.o_tready) begin
      tvalid_q <= 1'b0;
      final_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retrigger_cnt <= '0;
    end else if (accept && s.i_tlast && (state != S_IDLE) && (retrigger_cnt != 16'hFFFF)) begin
      retrigger_cnt <= retrigger_cnt + 16'd1;
    end
  end

  assign s.o_tdata    = data_q;
  assign s.o_tlast    = tlast_q;
  assign s.o_tuser    = tuser_q;
  assign s.o_tvalid   = tvalid_q;
  assign frame_active = (state != S_IDLE);
  assign frame_done   = tvalid_q & s.o_tready & final_q & ~abort;

endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// Directed bench for ofdm_symbol_sequencer: ramp stimulus, framing, backpressure,
// retrigger, zero-symbol, abort and asynchronous-reset scenarios.
module tb_ofdm_symbol_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic        frame_active, frame_done;
  logic [15:0] retrigger_cnt;

  ofdm_symbol_sequencer_if #(.WIDTH_SAMPLE(16)) bus ();

  ofdm_symbol_sequencer #(
    .WIDTH_SAMPLE(16), .FFT_SIZE(64), .CP_LEN(16), .SKIP_LEN_DEFAULT(320),
    .NUM_SYMBOLS_DEFAULT(1), .SR_NUM_SYMBOLS(7), .SR_SKIP_LEN(8), .SR_ABORT(9)
  ) dut (
    .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .s(bus.slave), .frame_active(frame_active), .frame_done(frame_done),
    .retrigger_cnt(retrigger_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int data; bit last; bit user;} beat_t;

  beat_t beats[$];
  beat_t exp_q[$];
  int    vec_cnt = 0, miss_cnt = 0;
  int    n, trig_a, trig_b, done_cnt, bad_stall, ready_low, last_cycles;
  int    abort_at, abort_phase;
  bit    src_on, rand_rdy, fa_seen, abort_next_vld;

  // Expected symbols for a trigger at ramp value trig: preamble + CP, then
  // 64-sample symbols spaced by 80 ramp values.
  function automatic void build_expect(int trig, int nsym, int skip);
    int first = trig + 1 + skip + 16;
    for (int k = 0; k < nsym; k++) begin
      for (int j = 0; j < 64; j++) begin
        beat_t b;
        b.data = first + k * 80 + j;
        b.last = (j == 63);
        b.user = (k == 0) && (j == 0);
        exp_q.push_back(b);
      end
    end
  endfunction

  function automatic int beat_errors();
    int e = 0;
    if (beats.size() != exp_q.size()) e++;
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++)
      if (beats[i] != exp_q[i]) e++;
    return e;
  endfunction

  function automatic bit in_exp(int v);
    foreach (exp_q[i]) if (exp_q[i].data == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic beat_t get_beat(int i);
    beat_t b = '{data: -1, last: 1'b0, user: 1'b0};
    if (i < beats.size()) b = beats[i];
    return b;
  endfunction

  task automatic clear_sb();
    beats.delete();
    exp_q.delete();
    done_cnt = 0; bad_stall = 0; ready_low = 0; fa_seen = 1'b0;
    trig_a = -1; trig_b = -1; abort_at = -1; abort_phase = 0; rand_rdy = 1'b0;
  endtask

  task automatic write_setting(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.i_tvalid = 1'b0;
    set_stb = 1'b1; set_addr = addr; set_data = data;
    @(negedge clk);
    set_stb = 1'b0;
  endtask

  // One clock: observe post-edge state, drive the next beat, then log the
  // handshakes that the coming edge will complete.
  task automatic step();
    @(negedge clk);
    if (frame_active) fa_seen = 1'b1;
    if (abort_phase == 2) begin
      abort_next_vld = bus.o_tvalid;
      set_stb = 1'b0;
      abort_phase = 3;
    end else if (abort_phase == 1 && bus.o_tvalid && int'(bus.o_tdata) == abort_at) begin
      set_stb = 1'b1; set_addr = 8'd9; set_data = 32'd0;
      abort_phase = 2;
    end
    bus.i_tvalid = src_on;
    bus.i_tdata  = 32'(n);
    bus.i_tlast  = (n == trig_a) || (n == trig_b);
    bus.o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (bus.o_tvalid && bus.o_tready)
      beats.push_back('{data: int'(bus.o_tdata), last: bus.o_tlast, user: bus.o_tuser});
    if (frame_done) done_cnt++;
    if (!bus.i_tready) ready_low++;
    if (bus.i_tvalid && !bus.i_tready && !in_exp(n)) bad_stall++;
    if (bus.i_tvalid && bus.i_tready) n++;
  endtask

  task automatic stream(input int n_start, input int n_end, input int budget);
    int cyc = 0;
    n = n_start;
    src_on = 1'b1;
    while (n < n_end && cyc < budget) begin
      step();
      cyc++;
    end
    last_cycles = cyc;
    vec_cnt++;
    if (n < n_end) begin
      miss_cnt++;
      $display("FAIL stream_timeout: reached n=%0d, required n=%0d", n, n_end);
    end
    src_on = 1'b0;
    rand_rdy = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    bus.i_tvalid = 1'b0; bus.i_tdata = '0; bus.i_tlast = 1'b0; bus.o_tready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({bus.o_tvalid, bus.o_tlast, bus.o_tuser, frame_active, frame_done} !== 5'b0) begin
      miss_cnt++;
      $display("FAIL reset_flags: got %b required 00000",
               {bus.o_tvalid, bus.o_tlast, bus.o_tuser, frame_active, frame_done});
    end
    vec_cnt++;
    if (bus.o_tdata !== 32'd0 || retrigger_cnt !== 16'd0) begin
      miss_cnt++;
      $display("FAIL reset_data: o_tdata=%0h retrigger=%0d required 0/0", bus.o_tdata, retrigger_cnt);
    end
    vec_cnt++;
    if (bus.i_tready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL reset_ready: i_tready=%b required 1", bus.i_tready);
    end
    reset = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (bus.i_tready !== 1'b1 || bus.o_tvalid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL post_reset: i_tready=%b o_tvalid=%b required 1/0", bus.i_tready, bus.o_tvalid);
    end
  endtask

  task automatic test_ramp();
    write_setting(8'd7, 32'd2);
    clear_sb();
    build_expect(10, 2, 320);
    trig_a = 10;
    stream(0, 520, 800);
    vec_cnt++;
    if (beats.size() !== 128) begin
      miss_cnt++; $display("FAIL ramp_count: got %0d required 128", beats.size());
    end
    vec_cnt++;
    if (get_beat(0).data !== 347 || get_beat(0).user !== 1'b1) begin
      miss_cnt++; $display("FAIL ramp_first: got %0d user=%b required 347 user=1", get_beat(0).data, get_beat(0).user);
    end
    vec_cnt++;
    if (get_beat(63).data !== 410 || get_beat(63).last !== 1'b1) begin
      miss_cnt++; $display("FAIL ramp_sym0_last: got %0d last=%b required 410 last=1", get_beat(63).data, get_beat(63).last);
    end
    vec_cnt++;
    if (get_beat(64).data !== 427 || get_beat(64).user !== 1'b0) begin
      miss_cnt++; $display("FAIL ramp_sym1_first: got %0d user=%b required 427 user=0", get_beat(64).data, get_beat(64).user);
    end
    vec_cnt++;
    if (get_beat(127).data !== 490 || get_beat(127).last !== 1'b1) begin
      miss_cnt++; $display("FAIL ramp_sym1_last: got %0d last=%b required 490 last=1", get_beat(127).data, get_beat(127).last);
    end
    vec_cnt++;
    if (beat_errors() !== 0) begin
      miss_cnt++; $display("FAIL ramp_sequence: %0d bad beats, required 0", beat_errors());
    end
    vec_cnt++;
    if (done_cnt !== 1) begin
      miss_cnt++; $display("FAIL ramp_done: got %0d pulses required 1", done_cnt);
    end
    vec_cnt++;
    if (last_cycles !== 520) begin
      miss_cnt++; $display("FAIL ramp_throughput: %0d cycles for 520 beats required 520", last_cycles);
    end
    vec_cnt++;
    if (fa_seen !== 1'b1 || frame_active !== 1'b0) begin
      miss_cnt++; $display("FAIL ramp_active: seen=%b final=%b required 1/0", fa_seen, frame_active);
    end
  endtask

  task automatic test_backpressure();
    clear_sb();
    build_expect(10, 2, 320);
    trig_a = 10;
    rand_rdy = 1'b1;
    stream(0, 520, 3000);
    vec_cnt++;
    if (beat_errors() !== 0) begin
      miss_cnt++; $display("FAIL bp_sequence: %0d bad beats of %0d, required 0", beat_errors(), beats.size());
    end
    vec_cnt++;
    if (bad_stall !== 0) begin
      miss_cnt++; $display("FAIL bp_stall: %0d stalls outside symbols required 0", bad_stall);
    end
    vec_cnt++;
    if (done_cnt !== 1) begin
      miss_cnt++; $display("FAIL bp_done: got %0d pulses required 1", done_cnt);
    end
  endtask

  task automatic test_retrigger();
    clear_sb();
    build_expect(10, 2, 320);
    trig_a = 10; trig_b = 200;
    stream(0, 520, 800);
    vec_cnt++;
    if (beat_errors() !== 0) begin
      miss_cnt++; $display("FAIL retrig_sequence: %0d bad beats required 0", beat_errors());
    end
    vec_cnt++;
    if (retrigger_cnt !== 16'd1) begin
      miss_cnt++; $display("FAIL retrig_count: got %0d required 1", retrigger_cnt);
    end
  endtask

  task automatic test_zero_symbols();
    write_setting(8'd7, 32'd0);
    clear_sb();
    trig_a = 10;
    stream(0, 520, 800);
    vec_cnt++;
    if (beats.size() !== 0) begin
      miss_cnt++; $display("FAIL zero_beats: got %0d required 0", beats.size());
    end
    vec_cnt++;
    if (fa_seen !== 1'b0 || ready_low !== 0) begin
      miss_cnt++; $display("FAIL zero_idle: active_seen=%b ready_low=%0d required 0/0", fa_seen, ready_low);
    end
    vec_cnt++;
    if (retrigger_cnt !== 16'd1 || done_cnt !== 0) begin
      miss_cnt++; $display("FAIL zero_counts: retrigger=%0d done=%0d required 1/0", retrigger_cnt, done_cnt);
    end
    write_setting(8'd7, 32'd2);
  endtask

  task automatic test_abort();
    clear_sb();
    build_expect(10, 2, 320);
    while (exp_q.size() > 0 && exp_q[$].data > 380) void'(exp_q.pop_back());
    build_expect(600, 2, 320);
    trig_a = 10; trig_b = 600;
    abort_at = 380; abort_phase = 1; abort_next_vld = 1'b1;
    stream(0, 1110, 1400);
    vec_cnt++;
    if (abort_phase !== 3 || abort_next_vld !== 1'b0) begin
      miss_cnt++; $display("FAIL abort_invalidate: phase=%0d o_tvalid=%b required 3/0", abort_phase, abort_next_vld);
    end
    vec_cnt++;
    if (get_beat(34).data !== 937 || get_beat(34).user !== 1'b1) begin
      miss_cnt++; $display("FAIL abort_restart: got %0d user=%b required 937 user=1", get_beat(34).data, get_beat(34).user);
    end
    vec_cnt++;
    if (beat_errors() !== 0) begin
      miss_cnt++; $display("FAIL abort_sequence: %0d bad beats required 0", beat_errors());
    end
    vec_cnt++;
    if (done_cnt !== 1) begin
      miss_cnt++; $display("FAIL abort_done: got %0d pulses required 1", done_cnt);
    end
  endtask

  task automatic test_async_reset();
    int cyc = 0;
    clear_sb();
    trig_a = 10;
    n = 0;
    src_on = 1'b1;
    while (!(beats.size() > 0 && beats[$].data == 360) && cyc < 600) begin
      step();
      cyc++;
    end
    vec_cnt++;
    if (beats.size() == 0 || beats[$].data != 360) begin
      miss_cnt++; $display("FAIL areset_reach: got %0d beats required to reach 360", beats.size());
    end
    #2 reset = 1'b1;
    #1;
    vec_cnt++;
    if ({bus.o_tvalid, bus.o_tlast, bus.o_tuser, frame_active, frame_done} !== 5'b0) begin
      miss_cnt++;
      $display("FAIL areset_flags: got %b required 00000",
               {bus.o_tvalid, bus.o_tlast, bus.o_tuser, frame_active, frame_done});
    end
    vec_cnt++;
    if (bus.o_tdata !== 32'd0 || retrigger_cnt !== 16'd0 || bus.i_tready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL areset_regs: o_tdata=%0h retrigger=%0d i_tready=%b required 0/0/1",
               bus.o_tdata, retrigger_cnt, bus.i_tready);
    end
    src_on = 1'b0;
    @(negedge clk);
    bus.i_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    write_setting(8'd7, 32'd2);
    clear_sb();
    build_expect(700, 2, 320);
    trig_a = 700;
    stream(690, 1210, 800);
    vec_cnt++;
    if (get_beat(0).data !== 1037 || get_beat(0).user !== 1'b1) begin
      miss_cnt++; $display("FAIL areset_first: got %0d user=%b required 1037 user=1", get_beat(0).data, get_beat(0).user);
    end
    vec_cnt++;
    if (beat_errors() !== 0 || done_cnt !== 1) begin
      miss_cnt++; $display("FAIL areset_frame: %0d bad beats, %0d done pulses, required 0/1", beat_errors(), done_cnt);
    end
  endtask

  initial begin
    clear_sb();
    n = 0;
    src_on = 1'b0;
    test_reset();
    test_ramp();
    test_backpressure();
    test_retrigger();
    test_zero_symbols();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/ofdm_symbol_sequencer.md
# ofdm_symbol_sequencer

Frame-level sequencer downstream of the OFDM plateau detector's AGC-corrected sample output. It uses the detector's trigger (`tlast`) to start a frame, discards the preamble, strips each symbol's cyclic prefix, and releases FFT_SIZE-sample symbols to the FFT with symbol framing. After a programmed number of symbols it returns to idle and re-arms for the next trigger.

## Interface
- `WIDTH_SAMPLE`, 16: I/Q component width; the stream word is `2*WIDTH_SAMPLE` bits.
- `FFT_SIZE`, 64: samples per released symbol. Must be a power of 2.
- `CP_LEN`, 16: cyclic-prefix samples discarded before each symbol.
- `SKIP_LEN_DEFAULT`, 320: reset value of skip length (short plus long preamble).
- `NUM_SYMBOLS_DEFAULT`, 1: reset value of symbols per frame.
- `SR_NUM_SYMBOLS`, 7: settings address for num_symbols, `set_data[7:0]`.
- `SR_SKIP_LEN`, 8: settings address for skip_len, `set_data[9:0]`.
- `SR_ABORT`, 9: settings address; any write aborts the current frame.
- `clk`  in  1  clock; one clock domain only.
- `reset`  in  1  asynchronous, active-high reset.
- `set_stb`  in  1  settings strobe.
- `set_addr`  in  8  settings address.
- `set_data`  in  32  settings data.
- `i_tdata`  in  2*WIDTH_SAMPLE  samples from the plateau detector.
- `i_tlast`  in  1  trigger: the next accepted sample is the first short-preamble sample.
- `i_tvalid`  in  1  input valid.
- `i_tready`  out  1  input ready.
- `o_tdata`  out  2*WIDTH_SAMPLE  symbol samples.
- `o_tlast`  out  1  marks the last sample of each symbol.
- `o_tuser`  out  1  marks the first sample of the first symbol of a frame.
- `o_tvalid`  out  1  output valid.
- `o_tready`  in  1  output ready.
- `frame_active`  out  1  high from trigger acceptance until the frame ends.
- `frame_done`  out  1  one-cycle pulse when the final `o_tlast` of a frame handshakes.
- `retrigger_cnt`  out  16  saturating count of triggers ignored during active frames.

## Operation
- Settings registers use the `setting_reg` style, reset to the defaults above.
  - num_symbols and skip_len are latched into working registers when a trigger is accepted. Mid-frame writes affect the next frame only.
  - A write to SR_ABORT causes: state=IDLE, output register invalidated, frame_active=0, no frame_done pulse.
- An input beat is "accepted" when `i_tvalid & i_tready`.
- States:
  - S_IDLE: `i_tready=1` and samples are discarded. An accepted beat with `i_tlast=1` does the following:
    - If latched num_symbols≠0: latch settings, clear counters, frame_active=1, go to S_SKIP (or S_CP if skip_len=0).
    - If num_symbols=0: ignore the trigger and stay in S_IDLE.
  - S_SKIP: `i_tready=1`. Discard skip_len accepted beats, then go to S_CP.
  - S_CP: `i_tready=1`. Discard CP_LEN accepted beats, then go to S_SYMBOL.
  - S_SYMBOL: `i_tready = ~o_tvalid | o_tready`. Each accepted beat loads the output register.
    - `o_tlast` is set on beat FFT_SIZE-1.
    - `o_tuser` is set on beat 0 of symbol 0.
    - After the last beat, symbol_cnt increments. If symbol_cnt equals num_symbols, go to S_IDLE with frame_active=0; otherwise go to S_CP.
- The sample counter is `$clog2(max(skip_len range, FFT_SIZE))` bits and resets at each state change. symbol_cnt is 8 bits.
- An `i_tlast` accepted in any non-IDLE state is ignored, the frame continues, and retrigger_cnt increments (saturating at 0xFFFF).
- The `i_tlast` bit is never forwarded to `o_tlast`.
- frame_done fires on the handshake of the final symbol's `o_tlast`. If that handshake stalls, frame_done waits for it, even if the state machine is already in S_IDLE.
- If abort and a trigger arrive in the same cycle, abort wins and the trigger is dropped.

## Timing
- Reset values:
  - All outputs are 0: `o_tdata`, `o_tlast`, `o_tuser`, `o_tvalid`, `frame_active`, `frame_done`, `retrigger_cnt`.
  - `i_tready=1`, since reset enters S_IDLE.
- Latency is one cycle from input acceptance to `o_tvalid` (registered output, single stage).
- Full throughput: with `o_tready` held high, one sample per clock in every state.
- `o_tdata`, `o_tlast` and `o_tuser` stay stable while `o_tvalid & ~o_tready`.
- frame_active rises the cycle after the trigger is accepted. It falls the cycle after the last symbol beat is accepted at the input.
- The block is ready for a new trigger on the beat immediately after the frame's last input beat.
- An asynchronous reset mid-frame clears everything at once. The in-flight output beat is lost.

## Test plan
- Ramp input `i_tdata=n`, `i_tlast` at n=10, num_symbols=2, skip=320, `o_tready=1`:
  - Symbol 0 outputs samples 347..410, with `o_tuser` at 347 and `o_tlast` at 410.
  - Symbol 1 outputs samples 427..490, with `o_tlast` at 490.
  - frame_done pulses once; 128 beats total.
- Same stimulus with `o_tready` pseudo-random at 50%: the output sequence is identical with no drops or duplicates, and input stalls only in S_SYMBOL.
- Second trigger at n=200 during the frame: output is unchanged from the first test, and retrigger_cnt=1.
- num_symbols=0 with a trigger: no output beats, frame_active stays 0, and `i_tready` stays 1.
- Write to SR_ABORT at output sample 380: `o_tvalid=0` on the next cycle, no frame_done. A fresh trigger at n=600 then yields a first sample of 937 with `o_tuser=1`.
- Assert `reset` asynchronously mid-symbol: all outputs read 0 within the same cycle, and a following trigger produces the frame from the first test offset accordingly.
